// File: rtl/fir_axilite_cfg_if.sv
// AXI-Lite write/read channel bundle (no write-response channel) for the FIR
// configuration port. The host drives the master side, the responder the slave side.
interface fir_axilite_cfg_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_axilite_cfg.sv
// AXI-Lite responder for the FIR configuration space: ap_ctrl status FSM,
// data_length register, and arbitration of the single-port tap BRAM between
// host coefficient access and the FIR engine.
module fir_axilite_cfg #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  fir_axilite_cfg_if.slave       axi,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   eng_tap_EN,
  output logic                   ap_start,
  input  logic                   eng_done,
  output logic [31:0]            data_length
);

  // Control FSM encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  // Read FSM encoding
  localparam logic [1:0] RIdle = 2'd0;
  localparam logic [1:0] RAddr = 2'd1;
  localparam logic [1:0] RData = 2'd2;

  localparam logic [pADDR_WIDTH-1:0] AddrCtrl = '0;
  localparam logic [pADDR_WIDTH-1:0] AddrLen  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TapBase  = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TapLast  = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

  // Word-aligned address inside the coefficient window
  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && (a >= TapBase) && (a <= TapLast);
  endfunction

  logic [1:0]             ctrl_q, ctrl_d;
  logic                   ap_done_q, ap_done_d;
  logic [31:0]            len_q, len_d;
  logic                   wr_rdy_q, wr_rdy_d;
  logic [1:0]             rd_q, rd_d;
  logic [pADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                   rd_own_q, rd_own_d;
  logic                   rd_first_q, rd_first_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                   wr_req;
  logic                   wr_hs;
  logic                   ar_hs;
  logic                   eng_owns;
  logic                   ap_idle;
  logic [pDATA_WIDTH-1:0] rd_live;

  assign wr_req   = axi.awvalid & axi.wvalid;
  assign wr_hs    = wr_rdy_q & wr_req;
  assign eng_owns = (ctrl_q != StIdle);
  assign ap_idle  = (ctrl_q == StIdle);
  // A pending or in-flight write blocks the read address handshake
  assign ar_hs    = (rd_q == RIdle) & axi.arvalid & ~wr_req & ~wr_rdy_q;

  // Write channel: single-cycle ready pulse, only while the read side is idle
  always_comb begin
    wr_rdy_d = (rd_q == RIdle) & wr_req & ~wr_rdy_q;
  end

  // Control FSM and data_length; host writes are frozen while the engine runs
  always_comb begin
    ctrl_d    = ctrl_q;
    ap_done_d = ap_done_q;
    len_d     = len_q;
    case (ctrl_q)
      StIdle: begin
        if (wr_hs && (axi.awaddr == AddrCtrl) && axi.wdata[0]) begin
          ctrl_d    = StStart;
          ap_done_d = 1'b0;
        end
      end
      StStart: ctrl_d = StRun;
      StRun: begin
        if (eng_done) begin
          ctrl_d    = StIdle;
          ap_done_d = 1'b1;
        end
      end
      default: ctrl_d = StIdle;
    endcase
    if (wr_hs && !eng_owns && (axi.awaddr == AddrLen)) begin
      len_d = axi.wdata;
    end
  end

  // Read data source for the captured address
  always_comb begin
    rd_live = '0;
    if (raddr_q == AddrCtrl) begin
      rd_live = pDATA_WIDTH'({ap_idle, ap_done_q, ap_start});
    end else if (raddr_q == AddrLen) begin
      rd_live = len_q;
    end else if (is_tap(raddr_q)) begin
      // Engine owned the BRAM during the address phase, so no coefficient was fetched
      rd_live = rd_own_q ? '1 : tap_Do;
    end
  end

  // Read FSM: address capture, BRAM fetch, then hold response until rready
  always_comb begin
    rd_d       = rd_q;
    raddr_d    = raddr_q;
    rd_own_d   = rd_own_q;
    rd_first_d = rd_first_q;
    rdata_d    = rdata_q;
    case (rd_q)
      RIdle: begin
        if (ar_hs) begin
          raddr_d = axi.araddr;
          rd_d    = RAddr;
        end
      end
      RAddr: begin
        rd_d       = RData;
        rd_own_d   = eng_owns;
        rd_first_d = 1'b1;
      end
      RData: begin
        // tap_Do is only valid in the first data cycle; freeze it for the hold
        if (rd_first_q) begin
          rdata_d    = rd_live;
          rd_first_d = 1'b0;
        end
        if (axi.rready) begin
          rd_d = RIdle;
        end
      end
      default: rd_d = RIdle;
    endcase
  end

  // Tap BRAM port mux: engine owns it outside IDLE, otherwise host write/read
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (eng_owns) begin
      tap_EN = eng_tap_EN;
      tap_A  = eng_tap_A;
    end else if (wr_hs && is_tap(axi.awaddr)) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = axi.awaddr - TapBase;
      tap_Di = axi.wdata;
    end else if ((rd_q == RAddr) && is_tap(raddr_q)) begin
      tap_EN = 1'b1;
      tap_A  = raddr_q - TapBase;
    end
  end

  // State registers, asynchronous active-high reset
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ctrl_q     <= StIdle;
      ap_done_q  <= 1'b0;
      len_q      <= '0;
      wr_rdy_q   <= 1'b0;
      rd_q       <= RIdle;
      raddr_q    <= '0;
      rd_own_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      ap_done_q  <= ap_done_d;
      len_q      <= len_d;
      wr_rdy_q   <= wr_rdy_d;
      rd_q       <= rd_d;
      raddr_q    <= raddr_d;
      rd_own_q   <= rd_own_d;
      rd_first_q <= rd_first_d;
      rdata_q    <= rdata_d;
    end
  end

  assign axi.awready = wr_rdy_q;
  assign axi.wready  = wr_rdy_q;
  assign axi.arready = ar_hs;
  assign axi.rvalid  = (rd_q == RData);
  assign axi.rdata   = ((rd_q == RData) && rd_first_q) ? rd_live : rdata_q;
  assign ap_start    = (ctrl_q == StStart);
  assign data_length = len_q;

endmodule

// File: tb/tb_fir_axilite_cfg.sv
// Self-checking bench for fir_axilite_cfg: directed scenarios plus a random
// phase, checked every cycle against a register-level model of the config space.
module tb_fir_axilite_cfg;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic [11:0] eng_tap_A;
  logic        eng_tap_EN;
  logic        ap_start;
  logic        eng_done;
  logic [31:0] data_length;

  fir_axilite_cfg_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_axilite_cfg #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk    (clk),
    .axis_rst    (rst),
    .axi         (bus),
    .tap_WE      (tap_WE),
    .tap_EN      (tap_EN),
    .tap_Di      (tap_Di),
    .tap_A       (tap_A),
    .tap_Do      (tap_Do),
    .eng_tap_A   (eng_tap_A),
    .eng_tap_EN  (eng_tap_EN),
    .ap_start    (ap_start),
    .eng_done    (eng_done),
    .data_length (data_length)
  );

  always #5 clk = ~clk;

  // Tap BRAM with 1-cycle read latency
  logic [31:0] bram [0:1023];
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[11:2]] <= tap_Di;
      tap_Do <= bram[tap_A[11:2]];
    end
  end

  // Reference model state
  logic [31:0] m_len;
  logic        m_run;
  logic        m_done;
  logic [31:0] m_tap [NT];
  logic        exp_start;
  logic [31:0] exp_q [$];
  int          cyc;
  int          ar_cyc;
  logic        prev_rvalid;
  logic [31:0] prev_rdata;
  int          n_cmp;
  int          n_fail;

  function automatic logic tap_addr(input logic [11:0] a);
    return (a[1:0] == 2'b00) && (a >= 12'h020) && (a <= 12'h020 + 12'(4 * (NT - 1)));
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    if (a == 12'h000) return m_run ? 32'h0 : (32'h4 | (m_done ? 32'h2 : 32'h0));
    if (a == 12'h010) return m_len;
    if (tap_addr(a)) return m_run ? 32'hFFFF_FFFF : m_tap[int'((a - 12'h020) >> 2)];
    return 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model by this cycle's events
  task automatic cycle_check();
    logic run_now;
    logic start_now;
    if (rst) begin
      m_len       = 32'h0;
      m_run       = 1'b0;
      m_done      = 1'b0;
      exp_start   = 1'b0;
      prev_rvalid = 1'b0;
      exp_q.delete();
      return;
    end
    cyc++;
    run_now   = m_run;
    start_now = exp_start;
    chk("data_length", data_length, m_len);
    chk("ap_start", 32'(ap_start), 32'(exp_start));
    if (run_now) begin
      chk("eng_tap_A", 32'(tap_A), 32'(eng_tap_A));
      chk("eng_tap_EN", 32'(tap_EN), 32'(eng_tap_EN));
      chk("eng_tap_WE", 32'(tap_WE), 32'h0);
    end
    if (bus.awready || bus.wready) chk("aw_w_ready", 32'(bus.wready), 32'(bus.awready));
    if (bus.arvalid && bus.awvalid && bus.wvalid) chk("wr_over_rd", 32'(bus.arready), 32'h0);
    if (bus.rvalid) begin
      if (!prev_rvalid) begin
        chk("rd_latency", 32'(cyc - ar_cyc), 32'd2);
        if (exp_q.size() > 0) chk("rdata", bus.rdata, exp_q.pop_front());
        else chk("rd_spurious", 32'(bus.rvalid), 32'h0);
      end else begin
        chk("rdata_hold", bus.rdata, prev_rdata);
        chk("arready_hold", 32'(bus.arready), 32'h0);
      end
    end
    prev_rvalid = bus.rvalid;
    prev_rdata  = bus.rdata;

    exp_start = 1'b0;
    // eng_done counts only in RUN (not in the START cycle)
    if (eng_done && run_now && !start_now) begin
      m_run  = 1'b0;
      m_done = 1'b1;
    end
    if (bus.awready && bus.awvalid && bus.wvalid && !run_now) begin
      if (bus.awaddr == 12'h000) begin
        if (bus.wdata[0]) begin
          m_run     = 1'b1;
          m_done    = 1'b0;
          exp_start = 1'b1;
        end
      end else if (bus.awaddr == 12'h010) begin
        m_len = bus.wdata;
      end else if (tap_addr(bus.awaddr)) begin
        chk("tap_wr_WE", 32'(tap_WE), 32'hF);
        chk("tap_wr_EN", 32'(tap_EN), 32'h1);
        chk("tap_wr_A", 32'(tap_A), 32'(bus.awaddr - 12'h020));
        chk("tap_wr_Di", tap_Di, bus.wdata);
        m_tap[int'((bus.awaddr - 12'h020) >> 2)] = bus.wdata;
      end
    end
    if (bus.arready && bus.arvalid) begin
      exp_q.push_back(exp_read(bus.araddr));
      ar_cyc = cyc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    eng_tap_A  = 12'($urandom);
    eng_tap_EN = 1'($urandom);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    int n;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.awaddr  = a;
    bus.wdata   = d;
    #1;
    n = 0;
    while (!bus.awready) begin
      if (n == 50) begin
        chk("wr_timeout", 32'(n), 32'd1);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        return;
      end
      step();
      n++;
    end
    chk("wr_latency", 32'(n), 32'd1);
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input int hold, output logic [31:0] d);
    int n;
    d           = 32'h0;
    bus.rready  = 1'b0;
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    #1;
    n = 0;
    while (!bus.arready) begin
      if (n == 50) begin
        chk("ar_timeout", 32'(n), 32'd0);
        bus.arvalid = 1'b0;
        return;
      end
      step();
      n++;
    end
    step();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid) begin
      if (n == 50) begin
        chk("r_timeout", 32'(n), 32'd0);
        return;
      end
      step();
      n++;
    end
    repeat (hold) step();
    d          = bus.rdata;
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
  endtask

  task automatic check_rst_outs();
    chk("rst_awready", 32'(bus.awready), 32'h0);
    chk("rst_wready", 32'(bus.wready), 32'h0);
    chk("rst_arready", 32'(bus.arready), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_tap_WE", 32'(tap_WE), 32'h0);
    chk("rst_tap_EN", 32'(tap_EN), 32'h0);
    chk("rst_ap_start", 32'(ap_start), 32'h0);
    chk("rst_data_length", data_length, 32'h0);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 12'h000;
      1: return 12'h010;
      2, 3: return 12'h020 + 12'(4 * $urandom_range(0, NT - 1));
      4: return 12'h020 + 12'(4 * $urandom_range(0, NT - 1)) + 12'($urandom_range(1, 3));
      5: return 12'h04C;
      6: return 12'($urandom);
      default: return 12'h01C;
    endcase
  endfunction

  initial begin
    int          coef [NT];
    logic [31:0] d;
    int          n;
    coef = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    ar_cyc = 0;
    prev_rvalid = 1'b0;
    prev_rdata = 32'h0;
    exp_start = 1'b0;
    m_run = 1'b0;
    m_done = 1'b0;
    m_len = 32'h0;
    for (int i = 0; i < NT; i++) m_tap[i] = 32'h0;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    bus.awaddr = 12'h0;
    bus.wdata = 32'h0;
    bus.arvalid = 1'b0;
    bus.araddr = 12'h0;
    bus.rready = 1'b0;
    eng_tap_A = 12'h0;
    eng_tap_EN = 1'b0;
    eng_done = 1'b0;

    @(posedge clk);
    #1;
    check_rst_outs();
    step();
    step();
    rst = 1'b0;
    step();

    // Program length and coefficients, read everything back
    do_write(12'h010, 32'd600);
    for (int i = 0; i < NT; i++) do_write(12'h020 + 12'(4 * i), 32'(coef[i]));
    for (int i = 0; i < NT; i++) begin
      do_read(12'h020 + 12'(4 * i), 0, d);
      chk("coef_readback", d, 32'(coef[i]));
    end
    do_read(12'h010, 0, d);
    chk("len_readback", d, 32'd600);
    chk("len_port", data_length, 32'd600);

    // Status sequence: idle, start pulse, running, done
    do_read(12'h000, 0, d);
    chk("status_reset", d, 32'h4);
    do_write(12'h000, 32'h1);
    chk("start_pulse", 32'(ap_start), 32'h1);
    step();
    chk("start_once", 32'(ap_start), 32'h0);
    do_read(12'h000, 0, d);
    chk("status_run", d, 32'h0);
    pulse_done();
    do_read(12'h000, 0, d);
    chk("status_done", d, 32'h6);

    // Engine owns the tap port while running
    do_write(12'h000, 32'hFFFF_FFF1);
    step();
    eng_tap_A  = 12'h028;
    eng_tap_EN = 1'b1;
    #1;
    chk("follow_A", 32'(tap_A), 32'h028);
    chk("follow_EN", 32'(tap_EN), 32'h1);
    chk("follow_WE", 32'(tap_WE), 32'h0);
    do_write(12'h024, 32'd77);
    do_read(12'h024, 0, d);
    chk("tap_rd_in_run", d, 32'hFFFF_FFFF);
    do_write(12'h010, 32'd5);
    do_write(12'h000, 32'h1);
    chk("len_frozen", data_length, 32'd600);
    pulse_done();
    do_read(12'h024, 0, d);
    chk("tap_unchanged", d, 32'hFFFF_FFF6);
    do_write(12'h000, 32'h1);
    do_read(12'h000, 0, d);
    chk("done_cleared", d, 32'h0);
    pulse_done();

    // Response held under back-pressure
    do_read(12'h010, 5, d);
    chk("hold_read", d, 32'd600);

    // Simultaneous read and write: write handshakes first
    bus.araddr  = 12'h010;
    bus.arvalid = 1'b1;
    do_write(12'h010, 32'd1234);
    do_read(12'h010, 0, d);
    chk("wr_first", d, 32'd1234);

    // Unmapped and misaligned addresses read as zero
    do_read(12'h04C, 0, d);
    chk("past_window", d, 32'h0);
    do_read(12'h022, 0, d);
    chk("misaligned_tap", d, 32'h0);
    do_read(12'h012, 1, d);
    do_read(12'h004, 0, d);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0, 1: do_write(pick_addr(), $urandom);
        2, 3: do_read(pick_addr(), $urandom_range(0, 3), d);
        4: do_write(12'h000, $urandom);
        default: pulse_done();
      endcase
      repeat ($urandom_range(0, 2)) step();
    end
    pulse_done();
    step();

    // Reset while a read response is pending
    bus.araddr  = 12'h010;
    bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin
      step();
      n++;
    end
    step();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin
      step();
      n++;
    end
    chk("rdata_phase_reached", 32'(bus.rvalid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_rst_outs();
    step();
    rst = 1'b0;
    step();
    do_read(12'h000, 0, d);
    chk("status_after_rst1", d, 32'h4);

    // Reset while running
    do_write(12'h010, 32'd9);
    do_write(12'h000, 32'h1);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check_rst_outs();
    step();
    rst = 1'b0;
    step();
    do_read(12'h000, 0, d);
    chk("status_after_rst2", d, 32'h4);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_axilite_cfg.md
Name: fir_axilite_cfg

Overview:
- AXI-Lite responder for the FIR configuration space. It terminates the host's AXI-Lite write and read channels and owns the ap_ctrl status FSM and the data_length register.
- It arbitrates the single-port tap BRAM (bram11, 1-cycle read latency) between host coefficient access and the FIR datapath engine.
- It sits between the AXI-Lite bus and the FIR stream/MAC engine, which consumes ap_start, data_length and the tap port.

Parameters:
pADDR_WIDTH, 12, AXI-Lite and BRAM address width
pDATA_WIDTH, 32, data width
Tape_Num, 11, number of coefficients; tap window is 0x20 to 0x20+4*(Tape_Num-1)

Ports:
axis_clk  in  1  single clock, rising edge
axis_rst  in  1  asynchronous active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  pADDR_WIDTH  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  pDATA_WIDTH  write data
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  pADDR_WIDTH  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  pDATA_WIDTH  read data
tap_WE  out  4  tap BRAM byte write enables
tap_EN  out  1  tap BRAM enable
tap_Di  out  pDATA_WIDTH  tap BRAM write data
tap_A  out  pADDR_WIDTH  tap BRAM byte address
tap_Do  in  pDATA_WIDTH  tap BRAM read data (valid 1 cycle after address)
eng_tap_A  in  pADDR_WIDTH  engine tap read address
eng_tap_EN  in  1  engine tap read enable
ap_start  out  1  one-cycle start pulse to engine
eng_done  in  1  one-cycle done pulse from engine (after last sm beat)
data_length  out  32  programmed sample count

Behaviour:
- Reset values: awready=wready=arready=rvalid=0, rdata=0, tap_WE=0, tap_EN=0, ap_start=0, data_length=0, ap_done=0, ap_idle=1. Reset mid-transaction aborts it and issues no response.
- Control FSM: IDLE -> START -> RUN -> IDLE.
  - IDLE: a write to 0x00 with wdata[0]=1 clears ap_done and moves to START.
  - START (1 cycle): ap_start=1, ap_idle=0.
  - RUN: ap_idle=0 until eng_done. On eng_done, go to IDLE, set ap_done=1 and ap_idle=1.
  - eng_done outside RUN is ignored.
- Register 0x00 read value: {29'b0, ap_idle, ap_done, ap_start}.
- Writes to 0x00 in START or RUN are dropped. Other wdata bits are ignored.
- Write channel: awready and wready rise together for exactly one cycle, the cycle after both awvalid and wvalid are seen high while the read FSM is in R_IDLE. The register or BRAM update occurs on that handshake edge.
- Write target decode:
  - 0x10: data_length <= wdata.
  - Tap window: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata.
  - Any other address: write is accepted and discarded.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA.
  - R_IDLE: when arvalid is high and no write is pending, arready=1 for one cycle and araddr is captured. A write wins if both requests arrive in the same cycle.
  - R_ADDR: for a tap address, drive tap_EN=1, tap_WE=0, tap_A=araddr-0x20.
  - R_DATA: rvalid=1 with rdata held stable until rready, then return to R_IDLE.
  - Read latency: rvalid is asserted 2 cycles after the arready cycle.
- Read data by address: 0x00 gives status; 0x10 gives data_length; tap window gives tap_Do; unmapped gives 0.
- Tap port ownership in START/RUN: tap_A, tap_EN and tap_WE are driven from eng_tap_A, eng_tap_EN and 0 regardless of host activity.
  - Host tap writes are dropped.
  - Host tap reads return 32'hFFFF_FFFF.
  - The 0x10 write is dropped (length is frozen while running).
- Addresses are checked as word-aligned. Any address with bits [1:0] not equal to 0 is treated as unmapped.
- No write-response channel and no error responses.

Test Plan:
- Reset, then write 0x10=600 and taps 0x20..0x48 = {0,-10,-9,23,56,63,56,23,-9,-10,0}, then read all back -> read data matches exactly; each rvalid is 2 cycles after arready; data_length=600.
- Read 0x00 after reset -> 0x4. Write 0x00=1 -> ap_start high for exactly one cycle, then read 0x00 -> 0x0. Pulse eng_done -> read 0x00 -> 0x6.
- In RUN, write 0x24=77, then read 0x24 -> rdata 0xFFFF_FFFF; tap_A follows eng_tap_A with tap_WE=0. After eng_done, read 0x24 -> -10 (unchanged).
- In RUN, write 0x10=5 and write 0x00=1 -> data_length stays 600 and no second ap_start pulse. Write 0x00=1 after done -> ap_done cleared and a new pulse is issued.
- Hold rready=0 for 5 cycles on a read of 0x10 -> rvalid and rdata stay stable and arready stays low. Simultaneous arvalid and awvalid/wvalid -> write handshake first, read completes afterwards.
- Assert axis_rst during R_DATA and during RUN -> all outputs return to reset values asynchronously; afterwards read 0x00 -> 0x4.
